// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one single-cycle ALU between requesters
module alu_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [NUM_REQ*32-1:0]  req_operand_1_i,
   input  logic [NUM_REQ*32-1:0]  req_operand_2_i,
   input  logic [NUM_REQ*7-1:0]   req_funct7_i,
   input  logic [NUM_REQ*3-1:0]   req_funct3_i,
   output logic [NUM_REQ-1:0]     rsp_valid_o,
   input  logic [NUM_REQ-1:0]     rsp_ready_i,
   output logic [31:0]            rsp_data_o,
   output logic [31:0]            alu_operand_1_o,
   output logic [31:0]            alu_operand_2_o,
   output logic [6:0]             alu_funct7_o,
   output logic [2:0]             alu_funct3_o,
   input  logic [31:0]            alu_result_i,
   output logic                   busy_o
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // Pointer starts at the last requester so requester 0 wins first after reset.
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] last_q;
   logic [IW-1:0] owner_q;
   logic [31:0]   alu_op1_q, alu_op2_q;
   logic [6:0]    alu_f7_q;
   logic [2:0]    alu_f3_q;
   logic [31:0]   rsp_data_q;

   logic [IW-1:0] grant;
   logic          grant_found;
   logic          req_hs;
   int            cand;

   // Round-robin search starting just after the last owner, wrapping around.
   always_comb begin
      grant       = last_q;
      grant_found = 1'b0;
      cand        = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!grant_found && req_valid_i[IW'(cand)]) begin
            grant_found = 1'b1;
            grant       = IW'(cand);
         end
      end
   end

   assign req_hs = (state_q == ST_IDLE) && grant_found;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one transaction in flight, response must be taken before the next grant.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_hs) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready_i[owner_q]) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state; non-owners never see valid or ready.
   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      busy_o      = (state_q != ST_IDLE);
      if (state_q == ST_IDLE && grant_found) begin
         req_ready_o[grant] = 1'b1;
      end
      if (state_q == ST_RESP) begin
         rsp_valid_o[owner_q] = 1'b1;
      end
   end

   // Operand capture on accept, result capture in EXEC; everything else holds.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q     <= LAST_RST;
         owner_q    <= '0;
         alu_op1_q  <= '0;
         alu_op2_q  <= '0;
         alu_f7_q   <= '0;
         alu_f3_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         if (req_hs) begin
            owner_q   <= grant;
            last_q    <= grant;
            alu_op1_q <= req_operand_1_i[grant*32 +: 32];
            alu_op2_q <= req_operand_2_i[grant*32 +: 32];
            alu_f7_q  <= req_funct7_i[grant*7 +: 7];
            alu_f3_q  <= req_funct3_i[grant*3 +: 3];
         end
         if (state_q == ST_EXEC) begin
            rsp_data_q <= alu_result_i;
         end
      end
   end

   assign alu_operand_1_o = alu_op1_q;
   assign alu_operand_2_o = alu_op2_q;
   assign alu_funct7_o    = alu_f7_q;
   assign alu_funct3_o    = alu_f3_q;
   assign rsp_data_o      = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [1:0]  req_valid_i = '0;
   logic [1:0]  req_ready_o;
   logic [63:0] req_operand_1_i = '0;
   logic [63:0] req_operand_2_i = '0;
   logic [13:0] req_funct7_i = '0;
   logic [5:0]  req_funct3_i = '0;
   logic [1:0]  rsp_valid_o;
   logic [1:0]  rsp_ready_i = '0;
   logic [31:0] rsp_data_o;
   logic [31:0] alu_operand_1_o;
   logic [31:0] alu_operand_2_o;
   logic [6:0]  alu_funct7_o;
   logic [2:0]  alu_funct3_o;
   logic [31:0] alu_result_i;
   logic        busy_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   // Stand-in ALU: funct3 000 is ADD (SUB with funct7 0x20), anything else yields 0.
   always_comb begin
      alu_result_i = 32'h0;
      if (alu_funct3_o == 3'b000) begin
         alu_result_i = (alu_funct7_o == 7'h20) ? alu_operand_1_o - alu_operand_2_o
                                                 : alu_operand_1_o + alu_operand_2_o;
      end
   end

   alu_arbiter #(.NUM_REQ(2)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_operand_1_i (req_operand_1_i),
      .req_operand_2_i (req_operand_2_i),
      .req_funct7_i    (req_funct7_i),
      .req_funct3_i    (req_funct3_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_data_o      (rsp_data_o),
      .alu_operand_1_o (alu_operand_1_o),
      .alu_operand_2_o (alu_operand_2_o),
      .alu_funct7_o    (alu_funct7_o),
      .alu_funct3_o    (alu_funct3_o),
      .alu_result_i    (alu_result_i),
      .busy_o          (busy_o)
   );

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3);
      req_operand_1_i[r*32 +: 32] = a;
      req_operand_2_i[r*32 +: 32] = b;
      req_funct7_i[r*7 +: 7]      = 7'h00;
      req_funct3_i[r*3 +: 3]      = f3;
      req_valid_i[r]              = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      req_valid_i = '0;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid_o); end
      vectors++; if (rsp_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data got %h want 0", rsp_data_o); end
      vectors++; if ({alu_operand_1_o, alu_operand_2_o, alu_funct7_o, alu_funct3_o} !== 74'h0) begin miscompares++; $display("FAIL reset_alu got %h/%h want 0", alu_operand_1_o, alu_operand_2_o); end
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
      vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL reset_ready_idle got %b want 00", req_ready_o); end
   endtask

   task automatic test_single_add();
      @(negedge clk_i);
      rsp_ready_i = 2'b11;
      set_req(0, 32'd5, 32'd7, 3'b000);
      #1;
      vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL single_ready got %b want 01", req_ready_o); end
      @(negedge clk_i);
      req_valid_i[0] = 1'b0;
      vectors++; if (busy_o !== 1'b1 || rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL single_exec busy %b rsp_valid %b want 1/00", busy_o, rsp_valid_o); end
      vectors++; if (alu_operand_1_o !== 32'd5 || alu_operand_2_o !== 32'd7) begin miscompares++; $display("FAIL single_alu_ops got %0d,%0d want 5,7", alu_operand_1_o, alu_operand_2_o); end
      vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL single_exec_ready got %b want 00", req_ready_o); end
      @(negedge clk_i);
      vectors++; if (rsp_valid_o !== 2'b01) begin miscompares++; $display("FAIL single_rsp_valid got %b want 01", rsp_valid_o); end
      vectors++; if (rsp_data_o !== 32'd12) begin miscompares++; $display("FAIL single_rsp_data got %0d want 12", rsp_data_o); end
      @(negedge clk_i);
      vectors++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin miscompares++; $display("FAIL single_done rsp_valid %b busy %b want 00/0", rsp_valid_o, busy_o); end
   endtask

   task automatic test_both_valid();
      do_reset();
      rsp_ready_i = 2'b11;
      set_req(0, 32'h10, 32'h20, 3'b000);
      set_req(1, 32'hFFFF_FFFF, 32'h1, 3'b000);
      #1;
      vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL both_first_grant got %b want 01", req_ready_o); end
      @(negedge clk_i);
      req_valid_i[0] = 1'b0;
      @(negedge clk_i);
      vectors++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== 32'h30) begin miscompares++; $display("FAIL both_rsp0 valid %b data %h want 01/00000030", rsp_valid_o, rsp_data_o); end
      @(negedge clk_i);
      vectors++; if (req_ready_o !== 2'b10) begin miscompares++; $display("FAIL both_second_grant got %b want 10", req_ready_o); end
      @(negedge clk_i);
      req_valid_i[1] = 1'b0;
      @(negedge clk_i);
      vectors++; if (rsp_valid_o !== 2'b10 || rsp_data_o !== 32'h0) begin miscompares++; $display("FAIL both_rsp1_wrap valid %b data %h want 10/00000000", rsp_valid_o, rsp_data_o); end
      @(negedge clk_i);
   endtask

   task automatic test_alternate();
      logic [1:0]  exp_g [4];
      logic [31:0] exp_d [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      exp_d[0] = 32'd3; exp_d[1] = 32'd30; exp_d[2] = 32'd3; exp_d[3] = 32'd30;
      do_reset();
      rsp_ready_i = 2'b11;
      set_req(0, 32'd1, 32'd2, 3'b000);
      set_req(1, 32'd10, 32'd20, 3'b000);
      for (int k = 0; k < 4; k++) begin
         #1;
         vectors++; if (req_ready_o !== exp_g[k]) begin miscompares++; $display("FAIL alt_grant_%0d got %b want %b", k, req_ready_o, exp_g[k]); end
         @(negedge clk_i);
         @(negedge clk_i);
         vectors++; if (rsp_valid_o !== exp_g[k] || rsp_data_o !== exp_d[k]) begin miscompares++; $display("FAIL alt_rsp_%0d valid %b data %0d want %b/%0d", k, rsp_valid_o, rsp_data_o, exp_g[k], exp_d[k]); end
         @(negedge clk_i);
      end
      req_valid_i = '0;
   endtask

   task automatic test_backpressure();
      @(negedge clk_i);
      rsp_ready_i = 2'b00;
      set_req(0, 32'd100, 32'd23, 3'b000);
      #1;
      vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL bp_grant got %b want 01", req_ready_o); end
      @(negedge clk_i);
      req_valid_i[0] = 1'b0;
      set_req(1, 32'd1, 32'd1, 3'b000);
      rsp_ready_i = 2'b10;
      @(negedge clk_i);
      for (int i = 0; i < 5; i++) begin
         vectors++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== 32'd123) begin miscompares++; $display("FAIL bp_hold_%0d valid %b data %0d want 01/123", i, rsp_valid_o, rsp_data_o); end
         vectors++; if (req_ready_o !== 2'b00 || busy_o !== 1'b1) begin miscompares++; $display("FAIL bp_stall_%0d ready %b busy %b want 00/1", i, req_ready_o, busy_o); end
         @(negedge clk_i);
      end
      rsp_ready_i = 2'b01;
      @(negedge clk_i);
      vectors++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin miscompares++; $display("FAIL bp_release valid %b busy %b want 00/0", rsp_valid_o, busy_o); end
      vectors++; if (req_ready_o !== 2'b10) begin miscompares++; $display("FAIL bp_next_grant got %b want 10", req_ready_o); end
      req_valid_i[1] = 1'b0;
      #1;
      vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL bp_withdraw got %b want 00", req_ready_o); end
      @(negedge clk_i);
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL bp_no_stale_grant busy %b want 0", busy_o); end
      rsp_ready_i = 2'b11;
   endtask

   task automatic test_unsupported();
      @(negedge clk_i);
      set_req(0, 32'd3, 32'd4, 3'b001);
      #1;
      vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL unsup_grant got %b want 01", req_ready_o); end
      @(negedge clk_i);
      req_valid_i[0] = 1'b0;
      vectors++; if (alu_funct3_o !== 3'b001) begin miscompares++; $display("FAIL unsup_funct3 got %b want 001", alu_funct3_o); end
      @(negedge clk_i);
      vectors++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== 32'h0) begin miscompares++; $display("FAIL unsup_rsp valid %b data %h want 01/00000000", rsp_valid_o, rsp_data_o); end
      @(negedge clk_i);
      vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL unsup_done got %b want 00", rsp_valid_o); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i);
      rsp_ready_i = 2'b11;
      set_req(0, 32'd9, 32'd9, 3'b000);
      @(negedge clk_i);
      req_valid_i[0] = 1'b0;
      vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_exec busy %b want 1", busy_o); end
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      vectors++; if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL rstmid_state busy %b valid %b want 0/00", busy_o, rsp_valid_o); end
      vectors++; if (alu_operand_1_o !== 32'h0 || rsp_data_o !== 32'h0) begin miscompares++; $display("FAIL rstmid_regs alu_op1 %h data %h want 0/0", alu_operand_1_o, rsp_data_o); end
      @(negedge clk_i);
      vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL rstmid_no_rsp got %b want 00", rsp_valid_o); end
      set_req(0, 32'd1, 32'd1, 3'b000);
      set_req(1, 32'd2, 32'd2, 3'b000);
      #1;
      vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL rstmid_regrant got %b want 01", req_ready_o); end
      req_valid_i = '0;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_both_valid();
      test_alternate();
      test_backpressure();
      test_unsupported();
      test_reset_mid();
      @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
